// File: rtl/freq_meter_pkg.sv
// Shared definitions for the gated frequency meter: state encoding and a
// constant-evaluable clog2 also used by the clock divider blocks.
package freq_meter_pkg;

  localparam int unsigned STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_GATE = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Number of bits needed to hold values 0..value-1 (0 for value<=1).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input followed by a
// rising-edge detector; edge_c is a one-clk pulse per synchronized rise.
module freq_meter_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic edge_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // prev_q follows the synchronized level every cycle, whatever the FSM does
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_c = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: counts sig_in rising edges over GATE_CYCLES clocks.
// Define FREQ_METER_CONTINUOUS_EN to re-arm the window after every result.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 1000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sig_in,
  output logic             busy,
  output logic [CNT_W-1:0] count_out,
  output logic             valid,
  output logic             overflow
);

  localparam int unsigned GATE_W = clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t             state;
  state_t             next_state;
  logic               edge_c;
  logic               arm_c;
  logic               gate_c;
  logic               done_c;
  logic [GATE_W-1:0]  gate_cnt;
  logic [CNT_W-1:0]   edge_cnt;
  logic               ovf_flag;

  freq_meter_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .edge_c (edge_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start) next_state = ST_GATE;
      ST_GATE: if (gate_cnt == GATE_LAST) next_state = ST_DONE;
`ifdef FREQ_METER_CONTINUOUS_EN
      ST_DONE: next_state = ST_GATE;
`else
      ST_DONE: next_state = ST_IDLE;
`endif
      default: next_state = ST_IDLE;
    endcase
  end

  // Control decodes; arm_c clears the counters on entry to a window
  always_comb begin
    arm_c  = 1'b0;
    gate_c = 1'b0;
    done_c = 1'b0;
    case (state)
      ST_IDLE: arm_c = start;
      ST_GATE: gate_c = 1'b1;
`ifdef FREQ_METER_CONTINUOUS_EN
      ST_DONE: begin
        done_c = 1'b1;
        arm_c  = 1'b1;
      end
`else
      ST_DONE: done_c = 1'b1;
`endif
      default: ;
    endcase
  end

  // Gate counter and saturating edge counter
  always_ff @(posedge clk) begin
    if (rst) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
    end else if (arm_c) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf_flag <= 1'b0;
    end else if (gate_c) begin
      gate_cnt <= gate_cnt + GATE_W'(1);
      if (edge_c) begin
        if (edge_cnt == CNT_MAX) ovf_flag <= 1'b1;
        else                     edge_cnt <= edge_cnt + CNT_W'(1);
      end
    end
  end

  // Result registers; count_out/overflow hold until the next DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      valid     <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
    end else begin
      busy  <= (state != ST_IDLE);
      valid <= done_c;
      if (done_c) begin
        count_out <= edge_cnt;
        overflow  <= ovf_flag;
      end
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: reset, counting, level-high, saturation,
// start re-pulse and mid-window reset, in both single-shot and continuous builds.
module tb_freq_meter;

  localparam int unsigned G = 100;
`ifdef FREQ_METER_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        sig_in = 1'b0;
  logic        busy_a, valid_a, overflow_a;
  logic        busy_b, valid_b, overflow_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;

  int n_checks = 0;
  int n_fail   = 0;

  int half_period = 5;
  bit hold_en     = 1'b0;
  bit hold_val    = 1'b0;
  int ph          = 0;

  logic        sel = 1'b0;
  logic        m_busy, m_valid, m_ovf;
  logic [15:0] m_count;

  always #5 clk = ~clk;

  freq_meter #(.GATE_CYCLES(G), .CNT_W(16), .SYNC_STAGES(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .sig_in(sig_in),
    .busy(busy_a), .count_out(count_a), .valid(valid_a), .overflow(overflow_a)
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .sig_in(sig_in),
    .busy(busy_b), .count_out(count_b), .valid(valid_b), .overflow(overflow_b)
  );

  assign m_busy  = sel ? busy_b     : busy_a;
  assign m_valid = sel ? valid_b    : valid_a;
  assign m_ovf   = sel ? overflow_b : overflow_a;
  assign m_count = sel ? {12'd0, count_b} : count_a;

  // Square-wave source, changes on the falling edge
  always @(negedge clk) begin
    if (hold_en) begin
      sig_in = hold_val;
    end else if (ph >= half_period - 1) begin
      sig_in = ~sig_in;
      ph = 0;
    end else begin
      ph = ph + 1;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_period(input int half);
    hold_en = 1'b0;
    half_period = half;
    repeat (6 * half + 4) tick();
  endtask

  // One start pulse, then watch G+3 cycles for the result
  task automatic run_window(input logic use_b, input int exp_cnt, input logic exp_ovf,
                            input string tag);
    int nvalid = 0;
    int at = -1;
    logic [15:0] cnt_seen = '0;
    logic ovf_seen = 1'b0;
    logic busy_done = 1'b0;
    logic busy_after = 1'b1;
    sel = use_b;
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    for (int i = 1; i <= int'(G) + 3; i++) begin
      tick();
      if (m_valid) begin
        nvalid++;
        at = i;
        cnt_seen = m_count;
        ovf_seen = m_ovf;
      end
      if (i == int'(G) + 1) busy_done = m_busy;
      if (i == int'(G) + 2) busy_after = m_busy;
    end
    check({tag, "_nvalid"}, nvalid, 1);
    check({tag, "_valid_at"}, at, G + 1);
    check({tag, "_count"}, cnt_seen, exp_cnt);
    check({tag, "_ovf"}, ovf_seen, exp_ovf);
    check({tag, "_busy_done"}, busy_done, 1);
    check({tag, "_busy_after"}, busy_after, CONT ? 1 : 0);
  endtask

  initial begin
    int nvalid;
    int vat [3];
    int vcnt [3];
    logic busy61;
    logic [15:0] cnt61;

    // 1: long reset with activity on every input
    rst = 1'b1;
    start_a = 1'b1;
    start_b = 1'b1;
    half_period = 3;
    repeat (20) tick();
    check("rst_busy", busy_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_count", count_a, 0);
    check("rst_ovf", overflow_a, 0);
    check("rst_b_busy", busy_b, 0);
    check("rst_b_count", count_b, 0);
    start_a = 1'b0;
    start_b = 1'b0;
    rst = 1'b0;
    tick();

    // 2: period 10 over 100 cycles -> 10 edges
    set_period(5);
    run_window(1'b0, 10, 1'b0, "p10");

    // 3: input stuck high
    apply_reset();
    hold_en = 1'b1;
    hold_val = 1'b1;
    repeat (10) tick();
    run_window(1'b0, 0, 1'b0, "hold1");

    // 4: 4-bit counter saturates, then recovers on a slower input
    apply_reset();
    set_period(2);
    run_window(1'b1, 15, 1'b1, "sat");
    apply_reset();
    set_period(10);
    run_window(1'b1, 5, 1'b0, "p20");

    // 5: start re-pulsed mid-window
    apply_reset();
    set_period(5);
    sel = 1'b0;
    nvalid = 0;
    vat = '{-1, -1, -1};
    vcnt = '{-1, -1, -1};
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 1; i <= 310; i++) begin
      tick();
      if (valid_a) begin
        if (nvalid < 3) begin
          vat[nvalid] = i;
          vcnt[nvalid] = int'(count_a);
        end
        nvalid++;
      end
      if (i == 49) start_a = 1'b1;
      if (i == 50) start_a = 1'b0;
    end
    check("repulse_valid_at0", vat[0], 101);
    check("repulse_count0", vcnt[0], 10);
`ifdef FREQ_METER_CONTINUOUS_EN
    check("cont_nvalid", nvalid, 3);
    check("cont_valid_at1", vat[1], 202);
    check("cont_valid_at2", vat[2], 303);
    check("cont_count1", vcnt[1], 10);
    check("cont_count2", vcnt[2], 10);
`else
    check("repulse_nvalid", nvalid, 1);
`endif

    // 6: reset mid-window, then a fresh measurement
    apply_reset();
    sel = 1'b0;
    nvalid = 0;
    vat = '{-1, -1, -1};
    vcnt = '{-1, -1, -1};
    busy61 = 1'b1;
    cnt61 = '1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 1; i <= 175; i++) begin
      tick();
      if (valid_a) begin
        if (nvalid < 3) begin
          vat[nvalid] = i;
          vcnt[nvalid] = int'(count_a);
        end
        nvalid++;
      end
      if (i == 61) begin
        busy61 = busy_a;
        cnt61 = count_a;
      end
      if (i == 59) rst = 1'b1;
      if (i == 60) rst = 1'b0;
      if (i == 69) start_a = 1'b1;
      if (i == 70) start_a = 1'b0;
    end
    check("midrst_busy61", busy61, 0);
    check("midrst_count_cleared", cnt61, 0);
    check("midrst_nvalid", nvalid, 1);
    check("midrst_valid_at", vat[0], 171);
    check("midrst_count", vcnt[0], 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
